alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares a single ArithLogicUnit instance between two requesters (requester 0: core execute stage; requester 1: auxiliary/debug port) through valid/ready handshakes. It grants one request per cycle and registers the ALU result. It holds that result on the granted requester's response channel until accepted. It sits beside the execute stage and is the only instantiator of the shared ALU.

## Interface
- FIRST_PRIO, default 0: requester that wins the first contested cycle after reset (0 or 1).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  bit i: requester i presents an operation.
- req_ready  out  2  bit i: operation of requester i accepted this cycle (one-hot or zero).
- req_fn0, req_fn1  in  alu_fn_t  ALU function per requester.
- req_a0, req_a1  in  word_t  operand a per requester.
- req_b0, req_b1  in  word_t  operand b per requester.
- rsp_valid  out  2  bit i: rsp_result belongs to requester i (one-hot or zero).
- rsp_ready  in  2  bit i: requester i consumes its response.
- rsp_result  out  word_t  registered ALU result.
- rsp_busy  out  1  result register occupied (OR of rsp_valid).

## Operation
- One result register, tagged with owner id. States: EMPTY (rsp_valid=00) and FULL (one rsp_valid bit set).
- can_accept = EMPTY, or FULL and rsp_ready[owner]=1 (same-cycle drain and refill).
- Grant: a single valid requester wins. If both are valid, the requester not granted most recently wins (round-robin). The last-grant pointer updates only on an accepted request.
- req_ready[i] = grant[i] & can_accept. Combinational from req_valid and rsp_ready. There is no path from req_ready back to req_valid.
- On accept: the ALU is driven with the winner's fn/a/b (instruction_t with only alu_fn meaningful, other fields zero). The result is captured into rsp_result, owner := winner, and the state goes to FULL.
- FULL with rsp_ready[owner]=0: the register holds, both req_ready are 0, and the last-grant pointer is unchanged.
- FULL with rsp_ready[owner]=1 and no accept: the state goes to EMPTY. rsp_result keeps its stale value, which is don't-care.
- rsp_ready of the non-owner is ignored.
- Requester protocol: once req_valid[i] is high, fn/a/b stay stable and valid stays high until req_ready[i]. The arbiter does not check this.
- ALU arithmetic is unchanged: 32-bit wrap-around add/sub, shift amount from b, SLT/SLTU return 0 or 1.

## Timing
- Reset values: req_ready=00, rsp_valid=00, rsp_busy=0, rsp_result=0, last-grant pointer = 1-FIRST_PRIO.
- Latency: request accepted at edge N, rsp_valid visible after edge N (cycle N+1).
- Throughput: one operation per cycle while the owner holds rsp_ready=1.
- Reset mid-operation: a pending result is discarded and not re-presented. Requests in flight must be re-issued.
- Simultaneous both valid, arbiter FULL and stalled: neither is granted. The pointer is unchanged, so the fairness order is preserved.
- Back-to-back by one requester with the other idle: granted every cycle, no bubble.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins when both are valid. The last-grant pointer is not implemented and FIRST_PRIO is ignored. Requester 1 can starve.
- Not defined: round-robin as above. This is the default build.

## Test plan
- After reset, both valid: req0 ADD a=5 b=7, req1 SUB a=10 b=3 -> cycle 1 grant req0 (FIRST_PRIO=0), cycle 2 rsp_valid=01 result 12. Cycle 2 grant req1, cycle 3 rsp_valid=10 result 7.
- Backpressure: req0 SLT a=0xFFFFFFFF b=1 accepted, rsp_ready=00 for 3 cycles -> rsp_valid=01 and result 1 held. req_ready=00 throughout, even with req1 valid.
- Streaming: req0 continuously valid with ADD a=k b=1 for k=0..7, rsp_ready[0]=1 -> one grant per cycle, results 1..8 in consecutive cycles.
- Fairness: both continuously valid, rsp_ready=11 -> grants alternate 0,1,0,1 for 8 cycles. With ALU_ARB_FIXED_PRIO_EN, req0 gets all 8 grants.
- Reset mid-operation: req1 SRA a=0x80000000 b=4 accepted, rsp_ready low, reset asserted for one cycle -> rsp_valid=00 and rsp_result=0 immediately (asynchronous). The result 0xF8000000 is never presented.
- Non-owner rsp_ready: FULL owned by req0, rsp_ready=10 -> no drain, state FULL holds.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ArithLogicUnit between two valid/ready requesters and holds a registered result.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins); default is round-robin.
package alu_arbiter_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_fn_t;

  typedef struct packed {
    alu_fn_t    alu_fn;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    word_t      imm;
  } instruction_t;

  typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_t;
endpackage

module ArithLogicUnit
  import alu_arbiter_pkg::*;
(
  input  instruction_t instr,
  input  word_t        a,
  input  word_t        b,
  output word_t        result
);
  logic [4:0] shamt;
  logic       unused_fields;

  assign shamt         = b[4:0];
  // Only alu_fn selects behaviour; the remaining instruction fields are carried but not decoded here.
  assign unused_fields = ^{instr.rd, instr.rs1, instr.rs2, instr.imm};

  always_comb begin
    result = '0;
    case (instr.alu_fn)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end
endmodule

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int FIRST_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  alu_fn_t    req_fn0,
  input  alu_fn_t    req_fn1,
  input  word_t      req_a0,
  input  word_t      req_a1,
  input  word_t      req_b0,
  input  word_t      req_b1,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output word_t      rsp_result,
  output logic       rsp_busy,
  output arb_state_t dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready depends on req_valid and rsp_ready only; rsp_valid is held until the owner's rsp_ready.
  arb_state_t   state;
  logic         owner;
  logic [1:0]   grant;
  logic         win;
  logic         can_accept;
  logic         accept;
  instruction_t alu_instr;
  word_t        alu_a;
  word_t        alu_b;
  word_t        alu_result;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam int unused_first_prio = FIRST_PRIO;

  always_comb begin
    grant = 2'b00;
    if (req_valid[0])      grant = 2'b01;
    else if (req_valid[1]) grant = 2'b10;
  end
`else
  logic last;

  // On contention the requester not granted most recently wins.
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) grant = last ? 2'b01 : 2'b10;
  end
`endif

  assign win        = grant[1];
  assign can_accept = (state == ARB_EMPTY) || rsp_ready[owner];
  assign req_ready  = (reset || !can_accept) ? 2'b00 : grant;
  assign accept     = |req_ready;
  assign dbg_state  = state;

  always_comb begin
    alu_instr        = '0;
    alu_instr.alu_fn = win ? req_fn1 : req_fn0;
    alu_a            = win ? req_a1 : req_a0;
    alu_b            = win ? req_b1 : req_b0;
  end

  ArithLogicUnit u_alu (
    .instr  (alu_instr),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_EMPTY;
      owner      <= 1'b0;
      rsp_valid  <= 2'b00;
      rsp_busy   <= 1'b0;
      rsp_result <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last       <= (FIRST_PRIO == 0);
`endif
    end else if (accept) begin
      state      <= ARB_FULL;
      owner      <= win;
      rsp_valid  <= grant;
      rsp_busy   <= 1'b1;
      rsp_result <= alu_result;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last       <= win;
`endif
    end else if (state == ARB_FULL && rsp_ready[owner]) begin
      // Drain without refill: the stale result stays in rsp_result.
      state      <= ARB_EMPTY;
      rsp_valid  <= 2'b00;
      rsp_busy   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors with literal expectations, plus a per-cycle compare against a transaction-level model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int FP = 0;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  alu_fn_t    fn0, fn1;
  word_t      a0, b0, a1, b1;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  word_t      rsp_result;
  logic       rsp_busy;
  arb_state_t dbg_state;

  int total = 0;
  int bad   = 0;

  // Model: pending responses as queues of (value, owner); last winner for fairness.
  logic [31:0] exp_q[$];
  int          own_q[$];
  int          m_last;

  alu_arbiter #(.FIRST_PRIO(FP)) dut (
    .clk        (clk),
    .reset      (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_fn0    (fn0),
    .req_fn1    (fn1),
    .req_a0     (a0),
    .req_a1     (a1),
    .req_b0     (b0),
    .req_b1     (b1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_busy   (rsp_busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input alu_fn_t fn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (fn)
      ALU_ADD:  return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      ALU_SUB:  return 32'(longint'(a) - longint'(b));
      ALU_SLL:  return 32'(longint'(a) * (64'd1 << sh));
      ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return 32'(longint'(a) / (64'd1 << sh));
      ALU_SRA:  return 32'(sa >>> sh);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic reset_model();
    exp_q.delete();
    own_q.delete();
    m_last = 1 - FP;
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input alu_fn_t f, input logic [31:0] a, input logic [31:0] b);
    fn0 = f; a0 = a; b0 = b;
  endtask

  task automatic drive1(input alu_fn_t f, input logic [31:0] a, input logic [31:0] b);
    fn1 = f; a1 = a; b1 = b;
  endtask

  // compare process: model decides the next edge's outcome from the inputs seen at the negedge
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_busy", 32'(rsp_busy), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
      end else begin
        int         w;
        int         own;
        bit         full;
        bit         can;
        logic [1:0] exp_rdy;
        logic [1:0] exp_vld;
        w = -1;
        if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          w = 0;
`else
          w = 1 - m_last;
`endif
        end else if (req_valid[0]) w = 0;
        else if (req_valid[1]) w = 1;
        full    = exp_q.size() != 0;
        own     = full ? own_q[0] : 0;
        can     = !full || rsp_ready[own];
        exp_rdy = (w >= 0 && can) ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
        exp_vld = full ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00;
        check("mdl_req_ready", 32'(req_ready), 32'(exp_rdy));
        check("mdl_rsp_valid", 32'(rsp_valid), 32'(exp_vld));
        check("mdl_rsp_busy", 32'(rsp_busy), 32'(full));
        check("mdl_dbg_state", 32'(dbg_state == ARB_FULL), 32'(full));
        if (full) check("mdl_rsp_result", rsp_result, exp_q[0]);
        if (full && rsp_ready[own]) begin
          void'(exp_q.pop_front());
          void'(own_q.pop_front());
        end
        if (exp_rdy != 2'b00) begin
          exp_q.push_back((w == 1) ? alu_model(fn1, a1, b1) : alu_model(fn0, a0, b0));
          own_q.push_back(w);
          m_last = w;
        end
      end
    end
  end

  // directed stimulus with hand-computed expectations
  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    drive0(ALU_ADD, 32'd0, 32'd0);
    drive1(ALU_ADD, 32'd0, 32'd0);
    reset_model();
    step();
    step();
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_busy", 32'(rsp_busy), 32'd0);
    check("reset_rsp_result", rsp_result, 32'd0);

    // both valid right after reset
    step();
    rst = 1'b0;
    drive0(ALU_ADD, 32'd5, 32'd7);
    drive1(ALU_SUB, 32'd10, 32'd3);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    @(negedge clk);
    check("first_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b10;
    @(negedge clk);
    check("first_rsp_valid", 32'(rsp_valid), 32'h1);
    check("first_rsp_result", rsp_result, 32'd12);
    check("second_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    check("second_rsp_valid", 32'(rsp_valid), 32'h2);
    check("second_rsp_result", rsp_result, 32'd7);
    step();
    rsp_ready = 2'b00;
    @(negedge clk);
    check("drain_rsp_valid", 32'(rsp_valid), 32'h0);

    // backpressure
    step();
    drive0(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    req_valid = 2'b01;
    @(negedge clk);
    check("bp_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b10;
    drive1(ALU_ADD, 32'd1, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp_rsp_result", rsp_result, 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'h0);
      step();
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    check("bp_refill_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    check("bp_refill_valid", 32'(rsp_valid), 32'h2);
    check("bp_refill_result", rsp_result, 32'd2);
    step();
    rsp_ready = 2'b11;
    step();
    rsp_ready = 2'b00;
    @(negedge clk);
    check("bp_drain_valid", 32'(rsp_valid), 32'h0);

    // non-owner rsp_ready is ignored
    step();
    drive0(ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0);
    req_valid = 2'b01;
    rsp_ready = 2'b10;
    @(negedge clk);
    check("nonown_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    check("nonown_result", rsp_result, 32'h0000_FF00);
    step();
    @(negedge clk);
    check("nonown_hold_valid", 32'(rsp_valid), 32'h1);
    check("nonown_hold_state", 32'(dbg_state == ARB_FULL), 32'd1);
    step();
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    @(negedge clk);
    check("nonown_drain_valid", 32'(rsp_valid), 32'h0);

    // streaming by requester 0
    for (int k = 0; k < 8; k++) begin
      step();
      rsp_ready = 2'b01;
      drive0(ALU_ADD, 32'(k), 32'd1);
      req_valid = 2'b01;
      @(negedge clk);
      check("stream_grant", 32'(req_ready), 32'h1);
      if (k > 0) check("stream_result", rsp_result, 32'(k));
    end
    step();
    req_valid = 2'b00;
    @(negedge clk);
    check("stream_last_valid", 32'(rsp_valid), 32'h1);
    check("stream_last_result", rsp_result, 32'd8);
    step();
    rsp_ready = 2'b00;
    @(negedge clk);
    check("stream_drain_valid", 32'(rsp_valid), 32'h0);

    // reset while a result is pending
    step();
    drive1(ALU_SRA, 32'h8000_0000, 32'd4);
    req_valid = 2'b10;
    @(negedge clk);
    check("rstmid_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b00;
    rst = 1'b1;
    reset_model();
    @(negedge clk);
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rstmid_rsp_result", rsp_result, 32'd0);
    step();
    rst = 1'b0;
    rsp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rstmid_no_replay", 32'(rsp_valid), 32'h0);
      step();
    end

    // fairness: both continuously valid
    drive0(ALU_OR, 32'd1, 32'd2);
    drive1(ALU_AND, 32'd6, 32'd3);
    req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifdef ALU_ARB_FIXED_PRIO_EN
      check("fair_grant", 32'(req_ready), 32'h1);
`else
      check("fair_grant", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
`endif
      if (i > 0) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        check("fair_result", rsp_result, 32'd3);
`else
        check("fair_result", rsp_result, (i % 2 == 1) ? 32'd3 : 32'd2);
`endif
      end
      step();
    end
    req_valid = 2'b00;
    step();
    step();
    rsp_ready = 2'b00;
    step();
    @(negedge clk);
    check("final_idle_valid", 32'(rsp_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
